// File: rtl/deco_pkg.sv
// Shared constants for the multi-digit 7-segment decoder: FSM encoding,
// active-low segment patterns (gfedcba) and the BCD digit table.
package deco_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/deco_digito.sv
// Combinational BCD nibble to active-low 7-segment pattern; error shows 'E'
// and takes priority over blanking.
module deco_digito
    import deco_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       error,
    output logic [6:0] seg
);

    always_comb begin
        if (error)      seg = SEG_E;
        else if (blank) seg = SEG_BLANK;
        else            seg = seg_digit(bcd);
    end

endmodule

// File: rtl/deco_7seg_multidigito.sv
// Signed value -> sequential double-dabble BCD -> time-multiplexed
// common-anode display (sign digit plus DIGITS magnitude digits).
module deco_7seg_multidigito
    import deco_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  entrada,
    input  logic              cargar,
    output logic              ocupado,
    output logic              listo,
    output logic              desborde,
    output logic [6:0]        salida,
    output logic [DIGITS:0]   anodo
);

    localparam int unsigned MAXV = pow10(DIGITS) - 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AN_W  = DIGITS + 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
    logic             disp_neg_q, disp_neg_d;
    logic             disp_ovf_q, disp_ovf_d;
    logic             listo_q, listo_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [AN_W-1:0]  anodo_q, anodo_d;
    logic [6:0]       salida_q, salida_d;

    logic [WIDTH-1:0] mag_in;
    logic [BCD_W-1:0] bcd_adj;
    logic [DIGITS-1:0] lz_blank;
    logic             seen_nz;
    logic [3:0]       cur_bcd;
    logic             cur_blank;
    logic [6:0]       dig_seg;

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        disp_bcd_d = disp_bcd_q;
        disp_neg_d = disp_neg_q;
        disp_ovf_d = disp_ovf_q;
        listo_d    = 1'b0;

        // Unsigned magnitude: -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
        mag_in = entrada[WIDTH-1] ? (~entrada + WIDTH'(1)) : entrada;

        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            ST_IDLE: begin
                if (cargar) begin
                    neg_d   = entrada[WIDTH-1];
                    mag_d   = mag_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 32'(mag_in) > MAXV;
                    state_d = ovf_d ? ST_DONE : ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, mag_d} = {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                disp_bcd_d = bcd_q;
                disp_neg_d = neg_q;
                disp_ovf_d = ovf_q;
                listo_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan divider/index and leading-zero mask for the committed digits.
    always_comb begin
        div_d = (div_q == DIV_W'(SCAN_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(DIGITS)) ? '0 : idx_q + IDX_W'(1);
        end

        lz_blank = '0;
        seen_nz  = 1'b0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            seen_nz     = seen_nz | (disp_bcd_q[4*i +: 4] != 4'd0);
            lz_blank[i] = (BLANK_LZ != 0) && !seen_nz;
        end

        cur_bcd   = disp_bcd_q[3:0];
        cur_blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd   = disp_bcd_q[4*i +: 4];
                cur_blank = lz_blank[i];
            end
        end
    end

    deco_digito u_digito (
        .bcd   (cur_bcd),
        .blank (cur_blank),
        .error (disp_ovf_q),
        .seg   (dig_seg)
    );

    always_comb begin
        salida_d = dig_seg;
        if (idx_q == IDX_W'(DIGITS)) salida_d = disp_neg_q ? SEG_MINUS : SEG_BLANK;
        anodo_d = ~(AN_W'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
            disp_ovf_q <= 1'b0;
            listo_q    <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            anodo_q    <= '1;
            salida_q   <= '1;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            disp_bcd_q <= disp_bcd_d;
            disp_neg_q <= disp_neg_d;
            disp_ovf_q <= disp_ovf_d;
            listo_q    <= listo_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            anodo_q    <= anodo_d;
            salida_q   <= salida_d;
        end
    end

    assign ocupado  = (state_q != ST_IDLE);
    assign listo    = listo_q;
    assign desborde = disp_ovf_q;
    assign salida   = salida_q;
    assign anodo    = anodo_q;

endmodule
